// File: rtl/img_mem_arbiter.sv
// Shares one single-port image RAM between the display scan (absolute priority)
// and a buffered write requester that only commits while the scan is outside the image window.
module img_mem_arbiter #(
    parameter int IMG_RES   = 256,
    parameter int IX_OFFSET = 20,
    parameter int IY_OFFSET = 20,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int X_POS_W   = 10,
    parameter int Y_POS_W   = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [X_POS_W-1:0] x_i,
    input  logic [Y_POS_W-1:0] y_i,
    output logic [DATA_W-1:0] pixel_o,
    output logic              pixel_valid_o,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [15:0]       coll_cnt_o,
    input  logic              coll_clr_i
);

    localparam int PIX_W = $clog2(IMG_RES);
    localparam logic [X_POS_W-1:0] X_LO = X_POS_W'(IX_OFFSET);
    localparam logic [X_POS_W-1:0] X_HI = X_POS_W'(IX_OFFSET + IMG_RES - 1);
    localparam logic [Y_POS_W-1:0] Y_LO = Y_POS_W'(IY_OFFSET);
    localparam logic [Y_POS_W-1:0] Y_HI = Y_POS_W'(IY_OFFSET + IMG_RES - 1);

    typedef enum logic {
        EMPTY,
        FULL
    } wrState_e;

    wrState_e          state_q, state_d;
    logic [ADDR_W-1:0] heldAddr_q, heldAddr_d;
    logic [DATA_W-1:0] heldData_q, heldData_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic              memWe_q, memWe_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    logic [15:0]       collCnt_q, collCnt_d;
    logic [1:0]        winPipe_q;
    logic [DATA_W-1:0] pixel_q, pixel_d;
    logic              pixelValid_q;

    logic              inWin;
    logic [PIX_W-1:0]  xRel;
    logic [PIX_W-1:0]  yRel;
    logic [ADDR_W-1:0] rdAddr;
    logic              wrReady;
    logic              capture;

    assign inWin  = (x_i >= X_LO) && (x_i <= X_HI) && (y_i >= Y_LO) && (y_i <= Y_HI);
    assign xRel   = PIX_W'(x_i - X_LO);
    assign yRel   = PIX_W'(y_i - Y_LO);
    assign rdAddr = ADDR_W'({yRel, xRel});

    always_comb begin
        state_d    = state_q;
        heldAddr_d = heldAddr_q;
        heldData_d = heldData_q;
        memAddr_d  = memAddr_q;
        memWe_d    = 1'b0;
        memWdata_d = memWdata_q;
        collCnt_d  = collCnt_q;
        wrReady    = 1'b0;

        case (state_q)
            EMPTY: begin
                wrReady = 1'b1;
                if (wr_valid_i) state_d = FULL;
            end
            FULL: begin
                // Draining frees the holding register, so a new write can land in the same cycle.
                if (!inWin) begin
                    wrReady = 1'b1;
                    if (!wr_valid_i) state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        capture = wr_valid_i && wrReady;
        if (capture) begin
            heldAddr_d = wr_addr_i;
            heldData_d = wr_data_i;
        end

        if (inWin) begin
            memAddr_d = rdAddr;
        end else if (state_q == FULL) begin
            memAddr_d  = heldAddr_q;
            memWdata_d = heldData_q;
            memWe_d    = 1'b1;
        end

        if (coll_clr_i) begin
            collCnt_d = '0;
        end else if ((state_q == FULL) && inWin && (collCnt_q != 16'hFFFF)) begin
            collCnt_d = collCnt_q + 16'd1;
        end

        pixel_d = winPipe_q[1] ? mem_rdata_i : '0;
    end

    assign wr_ready_o = wrReady;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= EMPTY;
            heldAddr_q   <= '0;
            heldData_q   <= '0;
            memAddr_q    <= '0;
            memWe_q      <= 1'b0;
            memWdata_q   <= '0;
            collCnt_q    <= '0;
            winPipe_q    <= '0;
            pixel_q      <= '0;
            pixelValid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            heldAddr_q   <= heldAddr_d;
            heldData_q   <= heldData_d;
            memAddr_q    <= memAddr_d;
            memWe_q      <= memWe_d;
            memWdata_q   <= memWdata_d;
            collCnt_q    <= collCnt_d;
            winPipe_q    <= {winPipe_q[0], inWin};
            pixel_q      <= pixel_d;
            pixelValid_q <= winPipe_q[1];
        end
    end

    assign mem_addr_o    = memAddr_q;
    assign mem_we_o      = memWe_q;
    assign mem_wdata_o   = memWdata_q;
    assign coll_cnt_o    = collCnt_q;
    assign pixel_o       = pixel_q;
    assign pixel_valid_o = pixelValid_q;

endmodule
